ctrl_pipeline: RTL and testbench

//  Pipelined successor to the single-cycle controller. Decodes the D-stage instruction and carries the control word

---
 rtl/ctrl_pkg.sv | 90 +++++++++
 rtl/ctrl_decode.sv | 166 ++++++++++++++++
 rtl/ctrl_pipeline.sv | 178 +++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared opcodes, control-word layout, forward selects and Tuse/Tnew codes.
// The MDU constants exist only when CTRL_MDU_EN is defined.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

`ifdef CTRL_MDU_EN
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
`endif

  localparam int CW_ALU    = 0;
  localparam int CW_IMM    = 2;
  localparam int CW_EXT    = 3;
  localparam int CW_DM_RE  = 5;
  localparam int CW_DM_WE  = 6;
  localparam int CW_GRF_WE = 7;
  localparam int CW_WD     = 8;
  localparam int CW_CMP    = 10;
  localparam int CW_NPC    = 11;
`ifdef CTRL_MDU_EN
  localparam int CW_MDU_START = 13;
  localparam int CW_MDU_OP    = 14;
  localparam int CW_MDU_WHI   = 16;
  localparam int CW_MDU_WLO   = 17;
  localparam int CW_MDU_RHI   = 18;
  localparam int CW_MDU_RLO   = 19;
  localparam int CW_MDU       = 20;
`endif

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_OR  = 2'd2;
  localparam logic [1:0] ALU_LUI = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_DM  = 2'd1;
  localparam logic [1:0] WD_PC8 = 2'd2;
`ifdef CTRL_MDU_EN
  localparam logic [1:0] WD_MDU = 2'd3;
  localparam logic [1:0] MDU_DIV  = 2'd2;
  localparam logic [1:0] MDU_DIVU = 2'd3;
`endif

  localparam logic [1:0] NPC_PC4 = 2'd0;
  localparam logic [1:0] NPC_BR  = 2'd1;
  localparam logic [1:0] NPC_J   = 2'd2;
  localparam logic [1:0] NPC_JR  = 2'd3;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_E   = 2'd1;
  localparam logic [1:0] FWD_M   = 2'd2;
  localparam logic [1:0] FWD_W   = 2'd3;

  localparam logic [1:0] TUSE_0  = 2'd0;
  localparam logic [1:0] TUSE_1  = 2'd1;
  localparam logic [1:0] TUSE_2  = 2'd2;
  localparam logic [1:0] TUSE_NA = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;

  // One stage older: producer is one cycle closer to its result.
  function automatic logic [1:0] tnew_age(input logic [1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - 2'd1;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Instruction decoder: control word, destination, Tuse per source, Tnew.
// MDU instructions decode only when CTRL_MDU_EN is defined.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int CTRL_W = 24,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] ctrl,
  output logic [REG_AW-1:0] wa,
  output logic [REG_AW-1:0] src_rs,
  output logic [REG_AW-1:0] src_rt,
  output logic [1:0]        tuse_rs,
  output logic [1:0]        tuse_rt,
  output logic [1:0]        tnew
);

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;
  logic       r_ok;

  assign op = instr[31:26];
  assign rs = instr[25:21];
  assign rt = instr[20:16];
  assign rd = instr[15:11];
  assign sh = instr[10:6];
  assign fn = instr[5:0];
  assign r_ok = (op == OP_RTYPE) && (sh == 5'd0);

  logic is_addu, is_subu, is_jr;
  logic is_ori, is_lw, is_sw;
  logic is_beq, is_lui, is_jal, is_j;

  assign is_addu = r_ok && (fn == FN_ADDU);
  assign is_subu = r_ok && (fn == FN_SUBU);
  assign is_jr   = r_ok && (fn == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_lui  = (op == OP_LUI);
  assign is_jal  = (op == OP_JAL);
  assign is_j    = (op == OP_J);

`ifdef CTRL_MDU_EN
  logic is_md, is_mf, is_mt;
  assign is_md = r_ok && (fn == FN_MULT || fn == FN_MULTU ||
                          fn == FN_DIV  || fn == FN_DIVU);
  assign is_mf = r_ok && (fn == FN_MFHI || fn == FN_MFLO);
  assign is_mt = r_ok && (fn == FN_MTHI || fn == FN_MTLO);
`endif

  always_comb begin
    ctrl = '0;
    ctrl[CW_ALU +: 2] = ALU_ADD;
    ctrl[CW_EXT +: 2] = EXT_ZERO;
    ctrl[CW_WD +: 2]  = WD_ALU;
    ctrl[CW_NPC +: 2] = NPC_PC4;
    wa      = '0;
    tuse_rs = TUSE_NA;
    tuse_rt = TUSE_NA;
    tnew    = TNEW_0;
    unique case (1'b1)
      is_addu, is_subu: begin
        ctrl[CW_ALU +: 2] = is_subu ? ALU_SUB : ALU_ADD;
        ctrl[CW_GRF_WE]   = 1'b1;
        wa      = REG_AW'(rd);
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
        tnew    = TNEW_1;
      end
      is_ori: begin
        ctrl[CW_ALU +: 2] = ALU_OR;
        ctrl[CW_IMM]      = 1'b1;
        ctrl[CW_EXT +: 2] = EXT_ZERO;
        ctrl[CW_GRF_WE]   = 1'b1;
        wa      = REG_AW'(rt);
        tuse_rs = TUSE_1;
        tnew    = TNEW_1;
      end
      is_lw: begin
        ctrl[CW_IMM]      = 1'b1;
        ctrl[CW_EXT +: 2] = EXT_SIGN;
        ctrl[CW_DM_RE]    = 1'b1;
        ctrl[CW_GRF_WE]   = 1'b1;
        ctrl[CW_WD +: 2]  = WD_DM;
        wa      = REG_AW'(rt);
        tuse_rs = TUSE_1;
        tnew    = TNEW_2;
      end
      is_sw: begin
        ctrl[CW_IMM]      = 1'b1;
        ctrl[CW_EXT +: 2] = EXT_SIGN;
        ctrl[CW_DM_WE]    = 1'b1;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_2;
      end
      is_beq: begin
        ctrl[CW_CMP]      = 1'b1;
        ctrl[CW_EXT +: 2] = EXT_SIGN;
        ctrl[CW_NPC +: 2] = NPC_BR;
        tuse_rs = TUSE_0;
        tuse_rt = TUSE_0;
      end
      is_lui: begin
        ctrl[CW_ALU +: 2] = ALU_LUI;
        ctrl[CW_IMM]      = 1'b1;
        ctrl[CW_EXT +: 2] = EXT_LUI;
        ctrl[CW_GRF_WE]   = 1'b1;
        wa   = REG_AW'(rt);
        tnew = TNEW_1;
      end
      is_jal: begin
        ctrl[CW_GRF_WE]   = 1'b1;
        ctrl[CW_WD +: 2]  = WD_PC8;
        ctrl[CW_NPC +: 2] = NPC_J;
        wa   = REG_AW'(5'd31);
        tnew = TNEW_0;
      end
      is_jr: begin
        ctrl[CW_NPC +: 2] = NPC_JR;
        tuse_rs = TUSE_0;
      end
      is_j: begin
        ctrl[CW_NPC +: 2] = NPC_J;
      end
`ifdef CTRL_MDU_EN
      is_md: begin
        ctrl[CW_MDU]         = 1'b1;
        ctrl[CW_MDU_START]   = 1'b1;
        ctrl[CW_MDU_OP +: 2] = fn[1:0];
        ctrl[CW_MDU_WHI]     = 1'b1;
        ctrl[CW_MDU_WLO]     = 1'b1;
        tuse_rs = TUSE_1;
        tuse_rt = TUSE_1;
      end
      is_mf: begin
        ctrl[CW_MDU]       = 1'b1;
        ctrl[CW_MDU_RHI]   = (fn == FN_MFHI);
        ctrl[CW_MDU_RLO]   = (fn == FN_MFLO);
        ctrl[CW_GRF_WE]    = 1'b1;
        ctrl[CW_WD +: 2]   = WD_MDU;
        wa   = REG_AW'(rd);
        tnew = TNEW_1;
      end
      is_mt: begin
        ctrl[CW_MDU]     = 1'b1;
        ctrl[CW_MDU_WHI] = (fn == FN_MTHI);
        ctrl[CW_MDU_WLO] = (fn == FN_MTLO);
        tuse_rs = TUSE_1;
      end
`endif
      default: ;
    endcase
  end

  // Sources that are not read report $0 so they never match a producer.
  assign src_rs = (tuse_rs == TUSE_NA) ? '0 : REG_AW'(rs);
  assign src_rt = (tuse_rt == TUSE_NA) ? '0 : REG_AW'(rt);

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined controller: D decode, E/M/W control regs, Tuse/Tnew stall, fwd.
// Define CTRL_MDU_EN to add the mult/div unit busy tracking.
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int CTRL_W = 24,
  parameter int REG_AW = 5
`ifdef CTRL_MDU_EN
  ,
  parameter int MDU_MUL_CYC = 5,
  parameter int MDU_DIV_CYC = 10
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       instr_d,
  output logic              stall_o,
  output logic [CTRL_W-1:0] ctrl_d,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic [CTRL_W-1:0] ctrl_m,
  output logic [CTRL_W-1:0] ctrl_w,
  output logic [REG_AW-1:0] wa_e,
  output logic [REG_AW-1:0] wa_m,
  output logic [REG_AW-1:0] wa_w,
  output logic [1:0]        fwd_rs_d,
  output logic [1:0]        fwd_rt_d,
  output logic [1:0]        fwd_rs_e,
  output logic [1:0]        fwd_rt_e,
  output logic              fwd_rt_m
);

  logic [REG_AW-1:0] wa_d;
  logic [REG_AW-1:0] rs_d;
  logic [REG_AW-1:0] rt_d;
  logic [1:0]        tuse_rs_d;
  logic [1:0]        tuse_rt_d;
  logic [1:0]        tnew_d;

  logic [1:0]        tnew_e;
  logic [1:0]        tnew_m;
  logic [REG_AW-1:0] rs_e;
  logic [REG_AW-1:0] rt_e;
  logic [REG_AW-1:0] rt_m;

  logic raw_stall;
  logic mdu_stall;

  ctrl_decode #(
    .CTRL_W (CTRL_W),
    .REG_AW (REG_AW)
  ) u_dec (
    .instr   (instr_d),
    .ctrl    (ctrl_d),
    .wa      (wa_d),
    .src_rs  (rs_d),
    .src_rt  (rt_d),
    .tuse_rs (tuse_rs_d),
    .tuse_rt (tuse_rt_d),
    .tnew    (tnew_d)
  );

  function automatic logic raw(
    input logic [REG_AW-1:0] src,
    input logic [1:0]        tuse,
    input logic [REG_AW-1:0] dst,
    input logic [1:0]        tnew
  );
    return (src != '0) && (src == dst) && (tuse < tnew);
  endfunction

  assign raw_stall = raw(rs_d, tuse_rs_d, wa_e, tnew_e) ||
                     raw(rs_d, tuse_rs_d, wa_m, tnew_m) ||
                     raw(rt_d, tuse_rt_d, wa_e, tnew_e) ||
                     raw(rt_d, tuse_rt_d, wa_m, tnew_m);

`ifdef CTRL_MDU_EN
  localparam int BUSY_MAX = (MDU_DIV_CYC > MDU_MUL_CYC) ?
                            MDU_DIV_CYC : MDU_MUL_CYC;
  localparam int BUSY_W = $clog2(BUSY_MAX + 1);

  logic [BUSY_W-1:0] busy;
  logic              e_is_div;

  assign e_is_div = (ctrl_e[CW_MDU_OP +: 2] == MDU_DIV) ||
                    (ctrl_e[CW_MDU_OP +: 2] == MDU_DIVU);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (ctrl_e[CW_MDU_START]) begin
      busy <= e_is_div ? BUSY_W'(MDU_DIV_CYC) : BUSY_W'(MDU_MUL_CYC);
    end else if (busy != '0) begin
      busy <= busy - 1'b1;
    end
  end

  assign mdu_stall = ctrl_d[CW_MDU] &&
                     ((busy != '0) || ctrl_e[CW_MDU_START]);
`else
  assign mdu_stall = 1'b0;
`endif

  assign stall_o = raw_stall || mdu_stall;

  // D compare operands: only jal's PC+8 is ready while still in E.
  always_comb begin
    fwd_rs_d = FWD_REG;
    if (rs_d != '0) begin
      if (rs_d == wa_e && tnew_e == TNEW_0)      fwd_rs_d = FWD_E;
      else if (rs_d == wa_m && tnew_m == TNEW_0) fwd_rs_d = FWD_M;
      else if (rs_d == wa_w)                     fwd_rs_d = FWD_W;
    end
  end

  always_comb begin
    fwd_rt_d = FWD_REG;
    if (rt_d != '0) begin
      if (rt_d == wa_e && tnew_e == TNEW_0)      fwd_rt_d = FWD_E;
      else if (rt_d == wa_m && tnew_m == TNEW_0) fwd_rt_d = FWD_M;
      else if (rt_d == wa_w)                     fwd_rt_d = FWD_W;
    end
  end

  always_comb begin
    fwd_rs_e = FWD_REG;
    if (rs_e != '0) begin
      if (rs_e == wa_m && tnew_m == TNEW_0) fwd_rs_e = FWD_M;
      else if (rs_e == wa_w)                fwd_rs_e = FWD_W;
    end
  end

  always_comb begin
    fwd_rt_e = FWD_REG;
    if (rt_e != '0) begin
      if (rt_e == wa_m && tnew_m == TNEW_0) fwd_rt_e = FWD_M;
      else if (rt_e == wa_w)                fwd_rt_e = FWD_W;
    end
  end

  assign fwd_rt_m = (rt_m != '0) && (rt_m == wa_w);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_e <= '0;
      wa_e   <= '0;
      tnew_e <= TNEW_0;
      rs_e   <= '0;
      rt_e   <= '0;
      ctrl_m <= '0;
      wa_m   <= '0;
      tnew_m <= TNEW_0;
      rt_m   <= '0;
      ctrl_w <= '0;
      wa_w   <= '0;
    end else begin
      if (stall_o) begin
        ctrl_e <= '0;
        wa_e   <= '0;
        tnew_e <= TNEW_0;
        rs_e   <= '0;
        rt_e   <= '0;
      end else begin
        ctrl_e <= ctrl_d;
        wa_e   <= wa_d;
        tnew_e <= tnew_d;
        rs_e   <= rs_d;
        rt_e   <= rt_d;
      end
      ctrl_m <= ctrl_e;
      wa_m   <= wa_e;
      tnew_m <= tnew_age(tnew_e);
      rt_m   <= rt_e;
      ctrl_w <= ctrl_m;
      wa_w   <= wa_m;
    end
  end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed table of per-cycle D instructions with hand-derived outputs,
// plus hand-written async-reset and bubble sequences.
module tb_ctrl_pipeline;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] instr_d;
  logic        stall_o;
  logic [23:0] ctrl_d, ctrl_e, ctrl_m, ctrl_w;
  logic [4:0]  wa_e, wa_m, wa_w;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipeline dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .instr_d  (instr_d),
    .stall_o  (stall_o),
    .ctrl_d   (ctrl_d),
    .ctrl_e   (ctrl_e),
    .ctrl_m   (ctrl_m),
    .ctrl_w   (ctrl_w),
    .wa_e     (wa_e),
    .wa_m     (wa_m),
    .wa_w     (wa_w),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  typedef struct {
    logic [31:0] instr;
    logic        st;
    logic [1:0]  rsd, rtd, rse, rte;
    logic        rtm;
    logic [4:0]  wae, wam, waw;
    logic [23:0] cd;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] r_i(input logic [5:0] fn,
      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_i(input logic [5:0] op,
      input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] im);
    return {op, rs, rt, im};
  endfunction

  function automatic vec_t mk(input logic [31:0] ins, input logic st,
      input logic [1:0] rsd, input logic [1:0] rtd,
      input logic [1:0] rse, input logic [1:0] rte, input logic rtm,
      input logic [4:0] wae, input logic [4:0] wam, input logic [4:0] waw,
      input logic [23:0] cd);
    vec_t v;
    v.instr = ins; v.st = st;
    v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte; v.rtm = rtm;
    v.wae = wae; v.wam = wam; v.waw = waw; v.cd = cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
      input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  logic [31:0] NOP, LW1, ADDU2, BEQ10, ORI1, BEQ11, JAL, JR31;
  logic [31:0] A0, A3, ORI4, SW4, LUI5, SUBU6, JMP, UNK, MULT, ORI3;
  logic [63:0] act, exp;

  initial begin
    NOP   = 32'h0;
    LW1   = i_i(6'h23, 5'd0, 5'd1, 16'h0);
    ADDU2 = r_i(6'h21, 5'd1, 5'd1, 5'd2);
    BEQ10 = i_i(6'h04, 5'd1, 5'd0, 16'h4);
    ORI1  = i_i(6'h0d, 5'd0, 5'd1, 16'h5);
    BEQ11 = i_i(6'h04, 5'd1, 5'd1, 16'h4);
    JAL   = {6'h03, 26'h10};
    JR31  = r_i(6'h08, 5'd31, 5'd0, 5'd0);
    A0    = r_i(6'h21, 5'd1, 5'd1, 5'd0);
    A3    = r_i(6'h21, 5'd0, 5'd0, 5'd3);
    ORI4  = i_i(6'h0d, 5'd0, 5'd4, 16'h7);
    SW4   = i_i(6'h2b, 5'd0, 5'd4, 16'h0);
    LUI5  = i_i(6'h0f, 5'd0, 5'd5, 16'h1234);
    SUBU6 = r_i(6'h23, 5'd5, 5'd5, 5'd6);
    JMP   = {6'h02, 26'h20};
    UNK   = 32'hFC21_0800;
    MULT  = r_i(6'h18, 5'd1, 5'd1, 5'd0);
    ORI3  = i_i(6'h0d, 5'd0, 5'd3, 16'h1);

    //            instr  st rsd rtd rse rte rtm wae wam waw ctrl_d
    vecs.push_back(mk(LW1,   0,0,0,0,0,0,  0, 0, 0, 24'h1AC));
    vecs.push_back(mk(ADDU2, 1,0,0,0,0,0,  1, 0, 0, 24'h080));
    vecs.push_back(mk(ADDU2, 0,0,0,0,0,0,  0, 1, 0, 24'h080));
    vecs.push_back(mk(NOP,   0,0,0,3,3,0,  2, 0, 1, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 2, 0, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 0, 2, 24'h000));
    vecs.push_back(mk(LW1,   0,0,0,0,0,0,  0, 0, 0, 24'h1AC));
    vecs.push_back(mk(BEQ10, 1,0,0,0,0,0,  1, 0, 0, 24'hC08));
    vecs.push_back(mk(BEQ10, 1,0,0,0,0,0,  0, 1, 0, 24'hC08));
    vecs.push_back(mk(BEQ10, 0,3,0,0,0,0,  0, 0, 1, 24'hC08));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 0, 0, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 0, 0, 24'h000));
    vecs.push_back(mk(ORI1,  0,0,0,0,0,0,  0, 0, 0, 24'h086));
    vecs.push_back(mk(BEQ11, 1,0,0,0,0,0,  1, 0, 0, 24'hC08));
    vecs.push_back(mk(BEQ11, 0,2,2,0,0,0,  0, 1, 0, 24'hC08));
    vecs.push_back(mk(NOP,   0,0,0,3,3,0,  0, 0, 1, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 0, 0, 24'h000));
    vecs.push_back(mk(JAL,   0,0,0,0,0,0,  0, 0, 0, 24'h1280));
    vecs.push_back(mk(JR31,  0,1,0,0,0,0, 31, 0, 0, 24'h1800));
    vecs.push_back(mk(NOP,   0,0,0,2,0,0,  0,31, 0, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  0, 0,31, 24'h000));
    vecs.push_back(mk(A0,    0,0,0,0,0,0,  0, 0, 0, 24'h080));
    vecs.push_back(mk(A3,    0,0,0,0,0,0,  0, 0, 0, 24'h080));
    vecs.push_back(mk(NOP,   0,0,0,0,0,0,  3, 0, 0, 24'h000));
    vecs.push_back(mk(ORI4,  0,0,0,0,0,0,  0, 3, 0, 24'h086));
    vecs.push_back(mk(SW4,   0,0,0,0,0,0,  4, 0, 3, 24'h04C));
    vecs.push_back(mk(NOP,   0,0,0,0,2,0,  0, 4, 0, 24'h000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,1,  0, 0, 4, 24'h000));
    vecs.push_back(mk(LUI5,  0,0,0,0,0,0,  0, 0, 0, 24'h097));
    vecs.push_back(mk(SUBU6, 0,0,0,0,0,0,  5, 0, 0, 24'h081));
    vecs.push_back(mk(JMP,   0,0,0,2,2,0,  6, 5, 0, 24'h1000));
    vecs.push_back(mk(NOP,   0,0,0,0,0,1,  0, 6, 5, 24'h000));
    vecs.push_back(mk(UNK,   0,0,0,0,0,0,  0, 0, 6, 24'h000));
    vecs.push_back(mk(MULT,  0,0,0,0,0,0,  0, 0, 0, 24'h000));

    reset_n = 1'b0;
    instr_d = NOP;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state",
        {stall_o, ctrl_e, ctrl_m, ctrl_w, wa_e, wa_m, wa_w}, 64'h0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      instr_d = vecs[i].instr;
      #1;
      act = {stall_o, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e,
             fwd_rt_m, wa_e, wa_m, wa_w, ctrl_d};
      exp = {vecs[i].st, vecs[i].rsd, vecs[i].rtd, vecs[i].rse,
             vecs[i].rte, vecs[i].rtm, vecs[i].wae, vecs[i].wam,
             vecs[i].waw, vecs[i].cd};
      chk($sformatf("vec%0d", i), act, exp);
    end

    // Async reset while a load-use stall is active.
    @(negedge clk); instr_d = ORI3;
    @(negedge clk); instr_d = LW1;
    @(negedge clk); instr_d = ADDU2;
    #1;
    chk("pre_rst_stall", {63'h0, stall_o}, 64'h1);
    chk("pre_rst_pipe", {ctrl_e, ctrl_m, wa_e, wa_m},
        {24'h1AC, 24'h086, 5'd1, 5'd3});
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst",
        {stall_o, ctrl_e, ctrl_m, ctrl_w, wa_e, wa_m, wa_w}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_stall", {63'h0, stall_o}, 64'h0);
    @(negedge clk);
    instr_d = NOP;
    #1;
    chk("post_rst_e", {ctrl_e, wa_e}, {24'h080, 5'd2});

    // Bubble contents and W-stage forwarding after a load-use stall.
    @(negedge clk); instr_d = LW1;
    @(negedge clk); instr_d = ADDU2;
    #1;
    chk("bub_stall", {63'h0, stall_o}, 64'h1);
    @(negedge clk);
    #1;
    chk("bubble_e", {stall_o, ctrl_e, wa_e, ctrl_m},
        {1'b0, 24'h0, 5'd0, 24'h1AC});
    @(negedge clk);
    instr_d = NOP;
    #1;
    chk("fwd_w_e", {fwd_rs_e, fwd_rt_e, ctrl_w, wa_w},
        {2'd3, 2'd3, 24'h1AC, 5'd1});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
